// File: rtl/mod_bus_arb_pkg.sv
// mod_bus_arb_pkg: shared FSM encodings, master ids and wait-counter width for the bus arbiter
package mod_bus_arb_pkg;
   localparam int WAIT_W = 4;
   localparam logic M_CPU = 1'b0;
   localparam logic M_DBG = 1'b1;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;
endpackage

// File: rtl/mod_bus_arb_if.sv
// mod_bus_arb_if: two-master request/ack bus plus the slave strobe bus; lock lines exist only with MOD_BUS_ARB_LOCK_EN
interface mod_bus_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_ack;
   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_ack;
   logic              s_de;
   logic              s_we;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [DATA_W-1:0] s_rdata;
   logic              s_gnt;
`ifdef MOD_BUS_ARB_LOCK_EN
   logic              m0_lock;
   logic              m1_lock;
`endif
   modport slave (
`ifdef MOD_BUS_ARB_LOCK_EN
      input  m0_lock, m1_lock,
`endif
      input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, s_rdata,
      output m0_rdata, m0_ack, m1_rdata, m1_ack, s_de, s_we, s_addr, s_wdata, s_gnt
   );
   modport master (
`ifdef MOD_BUS_ARB_LOCK_EN
      output m0_lock, m1_lock,
`endif
      output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, s_rdata,
      input  m0_rdata, m0_ack, m1_rdata, m1_ack, s_de, s_we, s_addr, s_wdata, s_gnt
   );
endinterface

// File: rtl/mod_bus_arb_rr.sv
// mod_bus_arb_rr: combinational 2-way round-robin picker with an optional sticky lock owner
module mod_bus_arb_rr (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_lock_vld,
   input  logic       i_lock_id,
   output logic       o_gnt_valid,
   output logic       o_gnt_id
);
   assign o_gnt_valid = |i_req;
   assign o_gnt_id    = (i_lock_vld && i_req[i_lock_id]) ? i_lock_id :
                        (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/mod_bus_arb.sv
// mod_bus_arb: two-master round-robin arbiter/sequencer for the strobe bus; MOD_BUS_ARB_LOCK_EN adds master lock
module mod_bus_arb
   import mod_bus_arb_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input logic           clk,
   input logic           rst,
   mod_bus_arb_if.slave  bus
);
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("mod_bus_arb: WAIT_STATES must be in 0..15");
   end

   state_t            r_state, w_next;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_we, r_gnt, r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
   logic [1:0]        w_req;
   logic              w_gnt_valid, w_gnt_id, w_grant, w_done, w_lock_vld;

   assign w_req   = {bus.m1_req, bus.m0_req};
   assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;
   assign w_done  = (r_state == ST_ACCESS) && (r_cnt == '0);

   mod_bus_arb_rr u_rr (
      .i_req       (w_req),
      .i_last      (r_last),
      .i_lock_vld  (w_lock_vld),
      .i_lock_id   (r_last),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

`ifdef MOD_BUS_ARB_LOCK_EN
   logic r_lock, r_locked;
   // lock sampled at grant becomes ownership for the master that just completed; dropped if owner idles
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lock   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         if (w_grant) r_lock <= w_gnt_id ? bus.m1_lock : bus.m0_lock;
         if (w_done) r_locked <= r_lock;
         else if (r_state == ST_IDLE && !w_req[r_last]) r_locked <= 1'b0;
      end
   end
   assign w_lock_vld = r_locked;
`else
   assign w_lock_vld = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else r_state <= w_next;
   end

   // next state and bus outputs; slave lines are forced to zero outside ACCESS
   always_comb begin
      w_next      = r_state;
      bus.s_de    = 1'b0;
      bus.s_we    = 1'b0;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      bus.s_gnt   = r_gnt;
      bus.m0_ack  = 1'b0;
      bus.m1_ack  = 1'b0;
      case (r_state)
         ST_IDLE: if (w_gnt_valid) w_next = ST_ACCESS;
         ST_ACCESS: begin
            bus.s_de    = 1'b1;
            bus.s_we    = r_we;
            bus.s_addr  = r_addr;
            bus.s_wdata = r_wdata;
            if (w_done) w_next = ST_ACK;
         end
         ST_ACK: begin
            w_next     = ST_IDLE;
            bus.m0_ack = (r_gnt == M_CPU);
            bus.m1_ack = (r_gnt == M_DBG);
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // grant capture, wait countdown, read-data capture and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_gnt    <= M_CPU;
         r_last   <= M_DBG;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_grant) begin
            r_gnt   <= w_gnt_id;
            r_we    <= w_gnt_id ? bus.m1_we    : bus.m0_we;
            r_addr  <= w_gnt_id ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_gnt_id ? bus.m1_wdata : bus.m0_wdata;
            r_cnt   <= WAIT_W'(WAIT_STATES);
         end else if (r_state == ST_ACCESS && !w_done) begin
            r_cnt <= r_cnt - WAIT_W'(1);
         end
         if (w_done) begin
            r_last <= r_gnt;
            if (!r_we && r_gnt == M_CPU) r_rdata0 <= bus.s_rdata;
            if (!r_we && r_gnt == M_DBG) r_rdata1 <= bus.s_rdata;
         end
      end
   end

   assign bus.m0_rdata = r_rdata0;
   assign bus.m1_rdata = r_rdata1;
endmodule
